// File: rtl/draw_rect_image.sv
// Overlays a 48x64 ROM image on the background at a per-frame latched (xpos, ypos).
// Optional colour-key transparency: define DRAW_RECT_IMAGE_TRANSPARENCY_EN.
module draw_rect_image #(
    parameter int unsigned RECT_WIDTH  = 48,
    parameter int unsigned RECT_HEIGHT = 64
`ifdef DRAW_RECT_IMAGE_TRANSPARENCY_EN
    ,
    parameter logic [11:0] TRANSPARENT_KEY = 12'h0F0
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [11:0] rgb_pixel,
    output logic [11:0] pixel_addr,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out
);

    localparam int unsigned SW = 13;
    localparam int unsigned CW = 11;
    localparam int unsigned PW = 12;

    logic [PW-1:0] x_lat;
    logic [PW-1:0] y_lat;

    logic          in_win;
    logic [5:0]    x_rel;
    logic [5:0]    y_rel;
    logic [PW-1:0] addr_d;

    logic [CW-1:0] vcount_s1;
    logic          vsync_s1;
    logic          vblnk_s1;
    logic [CW-1:0] hcount_s1;
    logic          hsync_s1;
    logic          hblnk_s1;
    logic [PW-1:0] rgb_s1;
    logic          in_win_s1;
    logic [PW-1:0] win_rgb;
    logic [PW-1:0] rgb_d;

    // Window test on 13-bit sums so positions near 4095 cannot wrap into view.
    always_comb begin
        in_win = (SW'(hcount_in) >= SW'(x_lat)) &&
                 (SW'(hcount_in) <  SW'(x_lat) + SW'(RECT_WIDTH)) &&
                 (SW'(vcount_in) >= SW'(y_lat)) &&
                 (SW'(vcount_in) <  SW'(y_lat) + SW'(RECT_HEIGHT));
        x_rel  = hcount_in[5:0] - x_lat[5:0];
        y_rel  = vcount_in[5:0] - y_lat[5:0];
        addr_d = in_win ? {y_rel, x_rel} : '0;
    end

    // Position only reloads at frame start so a move never tears the image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_lat <= '0;
            y_lat <= '0;
        end else if (hcount_in == '0 && vcount_in == '0) begin
            x_lat <= xpos;
            y_lat <= ypos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= '0;
            vcount_s1  <= '0;
            vsync_s1   <= 1'b0;
            vblnk_s1   <= 1'b0;
            hcount_s1  <= '0;
            hsync_s1   <= 1'b0;
            hblnk_s1   <= 1'b0;
            rgb_s1     <= '0;
            in_win_s1  <= 1'b0;
        end else begin
            pixel_addr <= addr_d;
            vcount_s1  <= vcount_in;
            vsync_s1   <= vsync_in;
            vblnk_s1   <= vblnk_in;
            hcount_s1  <= hcount_in;
            hsync_s1   <= hsync_in;
            hblnk_s1   <= hblnk_in;
            rgb_s1     <= rgb_in;
            in_win_s1  <= in_win;
        end
    end

    // ROM data arrives alongside stage-1; blanking beats the image.
    always_comb begin
`ifdef DRAW_RECT_IMAGE_TRANSPARENCY_EN
        win_rgb = (rgb_pixel == TRANSPARENT_KEY) ? rgb_s1 : rgb_pixel;
`else
        win_rgb = rgb_pixel;
`endif
        if (vblnk_s1 || hblnk_s1) begin
            rgb_d = '0;
        end else if (in_win_s1) begin
            rgb_d = win_rgb;
        end else begin
            rgb_d = rgb_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            vcount_out <= vcount_s1;
            vsync_out  <= vsync_s1;
            vblnk_out  <= vblnk_s1;
            hcount_out <= hcount_s1;
            hsync_out  <= hsync_s1;
            hblnk_out  <= hblnk_s1;
            rgb_out    <= rgb_d;
        end
    end

endmodule

// File: tb/tb_draw_rect_image.sv
// Randomized bench for draw_rect_image against a per-pixel behavioural model.
module tb_draw_rect_image;

    localparam int W = 48;
    localparam int H = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] vcount_in, hcount_in;
    logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic [11:0] rgb_in, xpos, ypos, rgb_pixel, pixel_addr;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic [11:0] rgb_out;

    int vectors = 0;
    int miscompares = 0;

    // Model state: latched position and the previous pixel's expected outputs.
    int          mx = 0, my = 0;
    logic [11:0] prev_rgb = '0;
    logic [25:0] prev_tim = '0;

    always #5 clk = ~clk;

    // Asynchronous ROM model: address as data, except one key-coloured texel.
    function automatic logic [11:0] rom(input logic [11:0] a);
        return (a == 12'h041) ? 12'h0F0 : a;
    endfunction

    assign rgb_pixel = rom(pixel_addr);

    draw_rect_image dut (
        .clk(clk), .rst_n(rst_n),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .rgb_pixel(rgb_pixel),
        .pixel_addr(pixel_addr),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one pixel, advance one clock, check address (1 clk) and outputs (2 clk).
    task automatic step(input int h, input int v, input logic hb, input logic vb,
                        input logic [11:0] rgb);
        bit          win;
        logic [11:0] addr, pix, cur_rgb;
        logic [25:0] cur_tim;
        logic        hs, vs;
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = hs;
        vsync_in  = vs;
        rgb_in    = rgb;
        if (!rst_n) begin
            addr = '0; cur_rgb = '0; cur_tim = '0; mx = 0; my = 0;
        end else begin
            win  = (h >= mx) && (h < mx + W) && (v >= my) && (v < my + H);
            addr = win ? 12'((v - my) * 64 + (h - mx)) : 12'h000;
            pix  = rom(addr);
`ifdef DRAW_RECT_IMAGE_TRANSPARENCY_EN
            if (pix == 12'h0F0) pix = rgb;
`endif
            cur_rgb = (hb || vb) ? 12'h000 : (win ? pix : rgb);
            cur_tim = {11'(v), vs, vb, 11'(h), hs, hb};
            if (h == 0 && v == 0) begin
                mx = int'(xpos);
                my = int'(ypos);
            end
        end
        @(posedge clk);
        #1;
        check("pixel_addr", 32'(pixel_addr), 32'(addr));
        check("rgb_out", 32'(rgb_out), 32'(prev_rgb));
        check("timing", 32'({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out}),
              32'(prev_tim));
        prev_rgb = cur_rgb;
        prev_tim = cur_tim;
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        check("rst_addr", 32'(pixel_addr), 32'h0);
        check("rst_rgb", 32'(rgb_out), 32'h0);
        check("rst_tim", 32'({vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out, hblnk_out}), 32'h0);
        prev_rgb = '0;
        prev_tim = '0;
        mx = 0;
        my = 0;
        for (int i = 0; i < cycles; i++)
            step(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom));
        rst_n = 1'b1;
    endtask

    function automatic logic [11:0] rnd_rgb();
        return 12'($urandom);
    endfunction

    function automatic logic rnd_blank();
        return ($urandom_range(0, 7) == 0);
    endfunction

    task automatic frame_start();
        step(0, 0, 1'b1, 1'b1, rnd_rgb());
    endtask

    // Random pixel biased toward the latched window boundary.
    task automatic near_window();
        int h, v;
        h = mx - 3 + int'($urandom_range(0, W + 5));
        v = my - 3 + int'($urandom_range(0, H + 5));
        if ($urandom_range(0, 4) == 0) h = int'($urandom_range(0, 2047));
        if ($urandom_range(0, 4) == 0) v = int'($urandom_range(0, 2047));
        h = h & 2047;
        v = v & 2047;
        if (h == 0 && v == 0) h = 1;
        step(h, v, rnd_blank(), rnd_blank(), rnd_rgb());
    endtask

    initial begin
        rst_n = 1'b0;
        xpos = 12'd100; ypos = 12'd50;
        hcount_in = '0; vcount_in = '0; hblnk_in = 0; vblnk_in = 0;
        hsync_in = 0; vsync_in = 0; rgb_in = '0;
        @(negedge clk);
        do_reset(5);

        // Static window at (100, 50): corners, right edge, blanking.
        frame_start();
        step(100, 50, 0, 0, 12'hABC);
        step(147, 113, 0, 0, 12'h456);
        step(148, 60, 0, 0, 12'h789);
        step(120, 60, 1, 0, 12'h321);
        step(120, 60, 0, 1, 12'h321);
        for (int v = 48; v < 116; v += 5)
            for (int h = 97; h < 152; h++) step(h, v, 0, 0, rnd_rgb());

        // Move mid-frame: remainder still at 100, next frame at 300.
        xpos = 12'd300;
        for (int h = 95; h < 155; h++) step(h, 100, 0, 0, rnd_rgb());
        for (int h = 295; h < 355; h++) step(h, 100, 0, 0, rnd_rgb());
        frame_start();
        for (int h = 95; h < 155; h++) step(h, 100, 0, 0, rnd_rgb());
        for (int h = 295; h < 355; h++) step(h, 100, 0, 0, rnd_rgb());

        // Colour-key texel at relative (1, 1) against background 12'h123.
        step(301, 51, 0, 0, 12'h123);
        step(302, 51, 0, 0, 12'h123);

        // Edge clip at (1000, 740) on a 1024x768 raster.
        xpos = 12'd1000; ypos = 12'd740;
        frame_start();
        for (int v = 736; v < 772; v += 3) begin
            for (int h = 995; h < 1024; h++) step(h, v, 0, 0, rnd_rgb());
            for (int h = 1; h < 6; h++) step(h, v, 0, 0, rnd_rgb());
        end

        // Near-wrap positions.
        xpos = 12'd4090; ypos = 12'd4080;
        frame_start();
        for (int i = 0; i < 40; i++) step(i & 7, i >> 3, 0, 0, rnd_rgb());

        // Random frames, with one mid-line reset.
        for (int f = 0; f < 14; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                xpos = 12'($urandom_range(0, 1100));
                ypos = 12'($urandom_range(0, 800));
            end else begin
                xpos = 12'($urandom);
                ypos = 12'($urandom);
            end
            frame_start();
            for (int i = 0; i < 200; i++) begin
                if (i == 100) begin
                    xpos = 12'($urandom_range(0, 1100));
                    ypos = 12'($urandom_range(0, 800));
                end
                near_window();
            end
            if (f == 6) do_reset(3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
